ifu_axi_fetch: RTL and testbench



---
 rtl/ifu_axi_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_ifu_axi_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: sequential instruction fetch over an AXI-lite read channel.
// Issues fetch PCs with a credit limit of FIFO_DEPTH (in-flight + buffered), tags
// each response with its PC from an in-order tag queue, and buffers the results
// toward the IDU. Redirects flush the buffer and drop stale in-flight responses.
// Optional build macro: IFU_FLOW_THROUGH_EN (zero-latency bypass when empty).
module ifu_axi_fetch #(
   parameter int unsigned        ADDR_W     = 32,
   parameter int unsigned        INST_W     = 32,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC   = 32'h8000_0000,
   parameter int unsigned        PC_STEP    = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [INST_W-1:0] rdata,
   input  logic [1:0]        rresp,
   output logic              rready,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_err,
   input  logic              inst_ready
);

   localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

   // Handshakes
   logic ar_hs, r_hs, out_hs;

   // Fetch / AR state
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   // Set when a redirect arrives while an AR is held but not yet accepted
   logic              stale_ar_q, stale_ar_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   // PC tag queue: one entry per accepted AR, popped per response
   logic [ADDR_W-1:0] tag_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  tag_wptr_q, tag_rptr_q;
   logic [ADDR_W-1:0] tag_head;

   // Instruction buffer
   logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
   logic              fifo_err  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              fifo_empty;
   logic              rsp_keep;
   logic              bypass;
   logic              fifo_push, fifo_pop;

   // Credit accounting
   logic [CNT_W:0]    used;
   logic              credit_idle, credit_b2b;

   assign rready   = 1'b1;
   assign arvalid  = arvalid_q;
   assign araddr   = araddr_q;

   assign ar_hs    = arvalid_q & arready;
   assign r_hs     = rvalid & rready;
   assign out_hs   = inst_valid & inst_ready;

   assign tag_head   = tag_mem[tag_rptr_q];
   assign fifo_empty = (count_q == '0);
   assign rsp_keep   = r_hs && (drop_cnt_q == '0);

`ifdef IFU_FLOW_THROUGH_EN
   assign bypass = fifo_empty && rsp_keep;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed response consumed in the same cycle never touches the buffer
   assign fifo_push = rsp_keep && !(bypass && out_hs);
   assign fifo_pop  = out_hs && !fifo_empty;

   // Space is reserved at issue time: in-flight plus buffered must stay below depth
   assign used        = {1'b0, inflight_q} + {1'b0, count_q};
   assign credit_idle = (used < DEPTH_W);
   assign credit_b2b  = ((used + 1'b1) < DEPTH_W);

   // Fetch PC, AR channel, in-flight and drop counter next-state
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      arvalid_d  = arvalid_q;
      araddr_d   = araddr_q;
      stale_ar_d = stale_ar_q;
      inflight_d = inflight_q;
      drop_cnt_d = drop_cnt_q;

      // Redirect wins; a stale AR being accepted must not advance the new PC
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (ar_hs && !stale_ar_q) begin
         fetch_pc_d = fetch_pc_q + PC_INC;
      end

      if (arvalid_q) begin
         if (arready) begin
            arvalid_d = credit_b2b;
            if (credit_b2b) begin
               araddr_d = fetch_pc_d;
            end
         end
      end else if (credit_idle) begin
         arvalid_d = 1'b1;
         araddr_d  = fetch_pc_d;
      end

      if (ar_hs) begin
         stale_ar_d = 1'b0;
      end
      if (redirect_valid && arvalid_q && !arready) begin
         stale_ar_d = 1'b1;
      end

      unique case ({ar_hs, r_hs})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase

      // Everything outstanding after a redirect cycle is stale
      if (redirect_valid) begin
         drop_cnt_d = inflight_q + CNT_W'(ar_hs) - CNT_W'(r_hs);
      end else begin
         if (r_hs && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_d - 1'b1;
         end
         if (ar_hs && stale_ar_q) begin
            drop_cnt_d = drop_cnt_d + 1'b1;
         end
      end
   end

   // Instruction buffer pointer/count next-state; redirect empties it
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (redirect_valid) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (fifo_push) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rptr_d = rptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
   end

   // Outputs toward the IDU: buffer head, or the live response when bypassing
   always_comb begin
      inst_valid = !fifo_empty;
      inst       = '0;
      inst_pc    = '0;
      inst_err   = 1'b0;
      if (!fifo_empty) begin
         inst     = fifo_inst[rptr_q];
         inst_pc  = fifo_pc[rptr_q];
         inst_err = fifo_err[rptr_q];
      end
`ifdef IFU_FLOW_THROUGH_EN
      if (bypass) begin
         inst_valid = 1'b1;
         inst       = rdata;
         inst_pc    = tag_head;
         inst_err   = |rresp;
      end
`endif
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         araddr_q   <= RESET_PC;
         arvalid_q  <= 1'b0;
         stale_ar_q <= 1'b0;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         tag_wptr_q <= '0;
         tag_rptr_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         araddr_q   <= araddr_d;
         arvalid_q  <= arvalid_d;
         stale_ar_q <= stale_ar_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         if (ar_hs) begin
            tag_wptr_q <= tag_wptr_q + 1'b1;
         end
         if (r_hs) begin
            tag_rptr_q <= tag_rptr_q + 1'b1;
         end
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   // Storage arrays; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         tag_mem[tag_wptr_q] <= araddr_q;
      end
      if (fifo_push && !redirect_valid) begin
         fifo_inst[wptr_q] <= rdata;
         fifo_pc[wptr_q]   <= tag_head;
         fifo_err[wptr_q]  <= |rresp;
      end
   end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Self-checking bench for ifu_axi_fetch: AXI-lite memory model, program-order
// reference model for delivered instructions, directed table and random phases.
module tb_ifu_axi_fetch;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        arvalid;
   logic [31:0] araddr;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        inst_ready;

   ifu_axi_fetch #(
      .ADDR_W     (32),
      .INST_W     (32),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RPC),
      .PC_STEP    (4)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .arvalid        (arvalid),
      .araddr         (araddr),
      .arready        (arready),
      .rvalid         (rvalid),
      .rdata          (rdata),
      .rresp          (rresp),
      .rready         (rready),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err),
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      int unsigned cyc;
   } req_t;

   typedef struct {
      logic [1:0]  rresp_in;
      logic [31:0] exp_araddr;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic        exp_err;
   } vec_t;

   req_t        mem_q[$];
   logic [1:0]  resp_map [logic [31:0]];
   logic [31:0] ar_log[$];
   logic [31:0] out_pc_log[$];
   int unsigned cyc = 0;
   int unsigned r_prob = 100;
   int unsigned rsp_cnt = 0;
   logic [31:0] exp_pc = RPC;
   logic        flush_chk = 1'b0;
   logic        prev_arvalid = 1'b0;
   logic        prev_arready = 1'b0;
   logic        prev_resetn = 1'b0;
   logic [31:0] prev_araddr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory content: response code per address
   function automatic logic [1:0] rresp_for(input logic [31:0] a);
      if (resp_map.exists(a)) return resp_map[a];
      return (a[4:2] == 3'd6) ? 2'b01 : 2'b00;
   endfunction

   // One clock: sample at negedge, update models, drive new inputs after posedge
   task automatic step();
      @(negedge clk);
      if (resetn && prev_resetn) begin
         if (prev_arvalid && !prev_arready) begin
            check("ar_hold_valid", 64'(arvalid), 64'(1));
            check("ar_hold_addr", 64'(araddr), 64'(prev_araddr));
         end
         if (flush_chk) check("flush_valid", 64'(inst_valid), 64'(0));
      end
      flush_chk = 1'b0;
      if (!resetn) begin
         exp_pc = RPC;
         mem_q.delete();
      end else begin
         if (inst_valid && inst_ready) begin
            check("out_pc", 64'(inst_pc), 64'(exp_pc));
            check("out_inst", 64'(inst), 64'(exp_pc ^ 32'hFFFF_FFFF));
            check("out_err", 64'(inst_err), 64'(rresp_for(exp_pc) != 2'b00));
            out_pc_log.push_back(inst_pc);
            exp_pc = exp_pc + 32'd4;
         end
         if (rvalid && rready && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            rsp_cnt++;
         end
         if (arvalid && arready) begin
            mem_q.push_back('{araddr, cyc});
            ar_log.push_back(araddr);
            check("outstanding_le_depth", 64'(mem_q.size() <= DEPTH), 64'(1));
         end
         if (redirect_valid) begin
            exp_pc    = redirect_pc;
            flush_chk = 1'b1;
         end
      end
      prev_arvalid = arvalid;
      prev_arready = arready;
      prev_araddr  = araddr;
      prev_resetn  = resetn;
      @(posedge clk);
      #1;
      cyc++;
      redirect_valid = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(99) < r_prob) begin
         rvalid = 1'b1;
         rdata  = mem_q[0].addr ^ 32'hFFFF_FFFF;
         rresp  = rresp_for(mem_q[0].addr);
      end else begin
         rvalid = 1'b0;
         rdata  = '0;
         rresp  = '0;
      end
   endtask

   task automatic do_reset();
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      arready        = 1'b0;
      inst_ready     = 1'b0;
      r_prob         = 100;
      repeat (3) step();
      resetn = 1'b1;
      ar_log.delete();
      out_pc_log.delete();
      rsp_cnt = 0;
   endtask

   function automatic logic [31:0] ar_at(input int i);
      return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] out_at(input int i);
      return (i < out_pc_log.size()) ? out_pc_log[i] : 32'hDEAD_BEEF;
   endfunction

   vec_t tbl[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = '0;

      tbl[0] = '{2'b00, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
      tbl[1] = '{2'b10, 32'h8000_0004, 32'h7FFF_FFFB, 32'h8000_0004, 1'b1};
      tbl[2] = '{2'b00, 32'h8000_0008, 32'h7FFF_FFF7, 32'h8000_0008, 1'b0};
      tbl[3] = '{2'b01, 32'h8000_000C, 32'h7FFF_FFF3, 32'h8000_000C, 1'b1};
      tbl[4] = '{2'b00, 32'h8000_0010, 32'h7FFF_FFEF, 32'h8000_0010, 1'b0};
      foreach (tbl[i]) resp_map[tbl[i].exp_araddr] = tbl[i].rresp_in;

      // Reset state
      do_reset();
      check("rst_arvalid", 64'(arvalid), 64'(0));
      check("rst_araddr", 64'(araddr), 64'(RPC));
      check("rst_rready", 64'(rready), 64'(1));
      check("rst_inst_valid", 64'(inst_valid), 64'(0));
      check("rst_inst", 64'(inst), 64'(0));
      check("rst_inst_pc", 64'(inst_pc), 64'(0));
      check("rst_inst_err", 64'(inst_err), 64'(0));

      // Sequential fetch, table-driven expectations
      arready    = 1'b1;
      inst_ready = 1'b1;
      repeat (20) step();
      for (int i = 0; i < 5; i++) begin
         check("tbl_araddr", 64'(ar_at(i)), 64'(tbl[i].exp_araddr));
         check("tbl_inst_pc", 64'(out_at(i)), 64'(tbl[i].exp_pc));
      end

      // Table: direct per-instruction inst/err check with stalled consumer
      do_reset();
      arready = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 4; i++) begin
         check("tbl_head_valid", 64'(inst_valid), 64'(1));
         check("tbl_head_inst", 64'(inst), 64'(tbl[i].exp_inst));
         check("tbl_head_pc", 64'(inst_pc), 64'(tbl[i].exp_pc));
         check("tbl_head_err", 64'(inst_err), 64'(tbl[i].exp_err));
         inst_ready = 1'b1;
         step();
         inst_ready = 1'b0;
         repeat (3) step();
      end

      // Full buffer with no consumer stops issue at depth
      do_reset();
      arready = 1'b1;
      repeat (20) step();
      check("full_ar_count", 64'(ar_log.size()), 64'(DEPTH));
      check("full_arvalid", 64'(arvalid), 64'(0));
      inst_ready = 1'b1;
      repeat (20) step();
      for (int i = 0; i < 4; i++) check("drain_pc", 64'(out_at(i)), 64'(RPC + 32'(4 * i)));
      check("resume_araddr", 64'(ar_at(4)), 64'(32'h8000_0010));

      // AR held under backpressure, then redirect while pending
      do_reset();
      waited = 0;
      while (!arvalid && waited < 10) begin
         step();
         waited++;
      end
      check("ar_rise_in_time", 64'(arvalid), 64'(1));
      repeat (5) begin
         step();
         check("hold_arvalid", 64'(arvalid), 64'(1));
         check("hold_araddr", 64'(araddr), 64'(RPC));
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_1000;
      step();
      step();
      check("pend_araddr_kept", 64'(araddr), 64'(RPC));
      arready    = 1'b1;
      inst_ready = 1'b1;
      repeat (20) step();
      check("pend_ar0", 64'(ar_at(0)), 64'(RPC));
      check("pend_ar1", 64'(ar_at(1)), 64'(32'h8000_1000));
      check("pend_first_out", 64'(out_at(0)), 64'(32'h8000_1000));

      // Redirect with responses in flight and entries buffered
      do_reset();
      arready = 1'b1;
      waited  = 0;
      while (rsp_cnt < 2 && waited < 20) begin
         step();
         waited++;
      end
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = '0;
      r_prob = 0;
      repeat (5) step();
      check("flight_outstanding", 64'(mem_q.size()), 64'(2));
      check("flight_buffered", 64'(inst_valid), 64'(1));
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_2000;
      step();
      check("redir_inst_valid", 64'(inst_valid), 64'(0));
      r_prob     = 100;
      inst_ready = 1'b1;
      repeat (25) step();
      check("redir_first_out", 64'(out_at(0)), 64'(32'h8000_2000));
      check("redir_no_old", 64'(out_pc_log.size() > 0), 64'(1));

      // Address wrap, redirect in first cycle out of reset
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      arready    = 1'b1;
      inst_ready = 1'b1;
      repeat (12) step();
      check("wrap_ar0", 64'(ar_at(0)), 64'(32'hFFFF_FFFC));
      check("wrap_ar1", 64'(ar_at(1)), 64'(32'h0000_0000));
      check("wrap_out1", 64'(out_at(1)), 64'(32'h0000_0000));

      // Random traffic against the program-order model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         arready    = ($urandom_range(99) < 70);
         inst_ready = ($urandom_range(99) < 60);
         r_prob     = 70;
         if ($urandom_range(99) < 3) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4
                                                      : ($urandom() & 32'hFFFF_FFFC);
         end
         step();
      end
      check("random_liveness", 64'(out_pc_log.size() > 200), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
